// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM port-0 initiator: FSM state encoding and the latched request.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_BE_W   = 4;
    localparam int unsigned SRAM_ADDR_W = 10;
    localparam int unsigned STATE_W     = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_BE_W-1:0]   be;
    } req_t;

endpackage

// File: rtl/sram_port0_ctrl.sv
// Single-outstanding valid/ready initiator for the RW port of the dummy SRAM model.
// Optional address range check enabled by defining SRAM_CTRL_RANGE_CHK_EN.
module sram_port0_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned NUM_WMASKS = SRAM_BE_W,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_WMASKS-1:0] req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    // Reject configurations the request struct or byte lanes cannot represent.
    if (DATA_WIDTH != 8 * NUM_WMASKS || DATA_WIDTH > SRAM_DATA_W || NUM_WMASKS > SRAM_BE_W ||
        ADDR_WIDTH > SRAM_ADDR_W || 64'(MEM_WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_cfg_err
        $error("sram_port0_ctrl: illegal parameter combination");
    end

    state_e                state_q;
    req_t                  req_q;
    logic                  csb_q;
    logic                  web_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  accept_c;

    assign accept_c = req_valid_i & ready_q;

`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic range_err_c;
    assign range_err_c = ({1'b0, req_addr_i} >= (ADDR_WIDTH + 1)'(MEM_WORDS));
`endif

    // Request register doubles as the SRAM pin register; be is cleared outside ISSUE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        ready_q <= 1'b0;
`ifdef SRAM_CTRL_RANGE_CHK_EN
                        if (range_err_c) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= ST_ISSUE;
                            csb_q       <= 1'b0;
                            web_q       <= ~req_we_i;
                            req_q.we    <= req_we_i;
                            req_q.addr  <= SRAM_ADDR_W'(req_addr_i);
                            req_q.wdata <= SRAM_DATA_W'(req_wdata_i);
                            req_q.be    <= req_we_i ? SRAM_BE_W'(req_be_i) : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    csb_q    <= 1'b1;
                    web_q    <= 1'b1;
                    req_q.be <= '0;
                    if (req_q.we) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                // dout0 settles on the mid-cycle negedge, so it is stable here.
                ST_WAIT: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= sram_dout_i;
                    rsp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = NUM_WMASKS'(req_q.be);
    assign sram_addr_o  = ADDR_WIDTH'(req_q.addr);
    assign sram_din_o   = DATA_WIDTH'(req_q.wdata);

endmodule
